// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared constants and the writeback queue entry type for the
// register-file write side (regfile_writeback and wb_queue).
package regfile_wb_pkg;
  localparam int XLEN   = 32;               // data width
  localparam int AW     = 5;                // register address width
  localparam int QDEPTH = 4;                // writeback queue entries (pow2, >= 2)
  localparam int QCW    = $clog2(QDEPTH) + 1;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: FIFO of wb_entry_t taking up to two pushes and one pop per cycle.
// Ports:
//   clock, reset           clock, async active-high reset
//   push0_i/push0_data_i   first push (older of the two)
//   push1_i/push1_data_i   second push; may be used without push0
//   pop_i                  drop the head entry
//   head_o                 current head entry (valid when count_o != 0)
//   count_o                occupancy
// The caller guarantees there is room for every push it issues.
module wb_queue
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = QDEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push0_i,
  input  wb_entry_t                  push0_data_i,
  input  logic                       push1_i,
  input  wb_entry_t                  push1_data_i,
  input  logic                       pop_i,
  output wb_entry_t                  head_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q, wptr1;
  logic [CW-1:0]   count_q;

  // push1 lands right behind push0 when both fire, otherwise at the tail.
  assign wptr1 = push0_i ? wptr_q + PW'(1) : wptr_q;

  always_ff @(posedge clock) begin
    if (push0_i) mem_q[wptr_q] <= push0_data_i;
    if (push1_i) mem_q[wptr1]  <= push1_data_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + PW'(push0_i) + PW'(push1_i);
      rptr_q  <= rptr_q + PW'(pop_i);
      count_q <= count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: write side of the 32x32 register file.
// Merges single-cycle ALU results and variable-latency load results into one
// registered write port (we3/a3/wd3), queueing losers, and keeps a per-register
// busy scoreboard for decode RAW/WAW stalls.
// Ports:
//   clock, reset                      clock, async active-high reset
//   issue_valid/issue_rd/issue_ready  decode issue; ready low on WAW
//   alu_valid/alu_rd/alu_data         ALU completion, no backpressure
//   mem_valid/mem_rd/mem_data         load completion, held until mem_ready
//   mem_ready                         queue has room for two pushes
//   rs1/rs2, rs1_busy/rs2_busy        source hazard lookup
//   we3/a3/wd3                        register file write port (registered)
//   q_count                           queue occupancy
//   err                               sticky protocol error
module regfile_writeback
  import regfile_wb_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            we3,
  output logic [AW-1:0]   a3,
  output logic [XLEN-1:0] wd3,
  output logic [QCW-1:0]  q_count,
  output logic            err
);
  logic [2**AW-1:0] busy_q, busy_d;
  logic             we3_q, err_q, err_set;
  logic [AW-1:0]    a3_q;
  logic [XLEN-1:0]  wd3_q;

  wb_entry_t        head, alu_e, mem_e, win_e, push0_e, push1_e;
  logic             head_v, alu_v, mem_v, win;
  logic             alu_push, mem_push, alu_ovf, push0, push1;

  assign alu_e  = '{rd: alu_rd, data: alu_data};
  assign mem_e  = '{rd: mem_rd, data: mem_data};

  assign head_v    = (q_count != '0);
  assign mem_ready = (q_count <= QCW'(QDEPTH - 2));
  // x0 completions are accepted but vanish here.
  assign alu_v     = alu_valid && (alu_rd != REG_ZERO);
  assign mem_v     = mem_valid && mem_ready && (mem_rd != REG_ZERO);

  assign issue_ready = (issue_rd == REG_ZERO) || !busy_q[issue_rd];
  assign rs1_busy    = busy_q[rs1] && (rs1 != REG_ZERO);
  assign rs2_busy    = busy_q[rs2] && (rs2 != REG_ZERO);

  always_comb begin
    win      = 1'b0;
    win_e    = head;
    alu_push = 1'b0;
    mem_push = 1'b0;
    if (head_v) begin
      win      = 1'b1;
      alu_push = alu_v;
      mem_push = mem_v;
    end else if (alu_v) begin
      win      = 1'b1;
      win_e    = alu_e;
      mem_push = mem_v;
    end else if (mem_v) begin
      win      = 1'b1;
      win_e    = mem_e;
    end
    // mem_ready already reserves two slots, so only the ALU push can overflow.
    alu_ovf = alu_push && (q_count == QCW'(QDEPTH)) && !head_v;

    // Compact pushes so the ALU entry is always older than the mem entry.
    push0   = (alu_push && !alu_ovf) || mem_push;
    push0_e = (alu_push && !alu_ovf) ? alu_e : mem_e;
    push1   = alu_push && !alu_ovf && mem_push;
    push1_e = mem_e;

    err_set = (alu_v && !busy_q[alu_rd]) || (mem_v && !busy_q[mem_rd]) || alu_ovf;

    // Clear on commit first so a same-edge issue to that register wins.
    busy_d = busy_q;
    if (we3_q) busy_d[a3_q] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != REG_ZERO)) busy_d[issue_rd] = 1'b1;
  end

  wb_queue #(.DEPTH(QDEPTH)) u_queue (
    .clock        (clock),
    .reset        (reset),
    .push0_i      (push0),
    .push0_data_i (push0_e),
    .push1_i      (push1),
    .push1_data_i (push1_e),
    .pop_i        (head_v),
    .head_o       (head),
    .count_o      (q_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      we3_q  <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      we3_q  <= win;
      if (win) begin
        a3_q  <= win_e.rd;
        wd3_q <= win_e.data;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign we3 = we3_q;
  assign a3  = a3_q;
  assign wd3 = wd3_q;
  assign err = err_q;
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0, alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]  issue_rd = '0, alu_rd = '0, mem_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        issue_ready, mem_ready, rs1_busy, rs2_busy, we3, err;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_errors = 0;

  regfile_writeback dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we3(we3), .a3(a3), .wd3(wd3), .q_count(q_count), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    idle();
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    @(posedge clock); #1;
  endtask

  // One cycle of a scripted issue with nothing else happening.
  task automatic issue_cycle(input logic [4:0] rd);
    idle();
    issue_valid = 1; issue_rd = rd;
    @(posedge clock); #1;
    idle();
  endtask

  typedef struct {
    logic        iv;  logic [4:0] ird;
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic [4:0]  r1;
    logic        e_ir; logic e_b1; logic e_we; logic [4:0] e_a3; logic [31:0] e_wd;
    logic [2:0]  e_q;  logic e_err;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [4:0] ird, logic av, logic [4:0] ard,
                              logic [31:0] ad, logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic [4:0] r1, logic e_ir, logic e_b1, logic e_we,
                              logic [4:0] e_a3, logic [31:0] e_wd, logic [2:0] e_q, logic e_err);
    vec_t v;
    v.iv = iv; v.ird = ird; v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.mrd = mrd; v.md = md; v.r1 = r1;
    v.e_ir = e_ir; v.e_b1 = e_b1; v.e_we = e_we; v.e_a3 = e_a3; v.e_wd = e_wd;
    v.e_q = e_q; v.e_err = e_err;
    return v;
  endfunction

  vec_t vecs[$];

  // Fill-and-drain expectations: ALU rd1..4 every cycle, loads rd5..8 held.
  logic       exp_mr [8] = '{1, 1, 1, 0, 0, 1, 1, 1};
  logic [2:0] exp_q  [8] = '{1, 2, 3, 3, 2, 2, 1, 0};
  logic [4:0] exp_a3 [8] = '{1, 5, 2, 6, 3, 7, 4, 8};

  initial begin
    //              iv ird  av ard ad        mv mrd md     r1  ir b1 we a3 wd        q  err
    vecs.push_back(mk(1, 5, 0, 0, 0,         0, 0, 0,      5,  1, 0, 0, 0, 0,        0, 0));
    vecs.push_back(mk(0, 0, 1, 5, 32'h1234,  0, 0, 0,      5,  1, 1, 1, 5, 32'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,         0, 0, 0,      5,  1, 1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,         0, 0, 0,      5,  1, 0, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 3, 0, 0, 0,         0, 0, 0,      0,  1, 0, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 4, 0, 0, 0,         0, 0, 0,      3,  1, 1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(0, 0, 1, 3, 32'hA,     1, 4, 32'hB,  3,  1, 1, 1, 3, 32'hA,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,         0, 0, 0,      4,  1, 1, 1, 4, 32'hB,    0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,         0, 0, 0,      3,  1, 0, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0,  0,  1, 0, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 7, 0, 0, 0,         0, 0, 0,      0,  1, 0, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 7, 0, 0, 0,         0, 0, 0,      7,  0, 1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 7, 1, 7, 32'h77,    0, 0, 0,      7,  0, 1, 1, 7, 32'h77,   0, 0));
    vecs.push_back(mk(1, 7, 0, 0, 0,         0, 0, 0,      7,  0, 1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 7, 0, 0, 0,         0, 0, 0,      7,  1, 0, 0, 0, 0,        0, 0));
    vecs.push_back(mk(0, 0, 1, 9, 32'h99,    0, 0, 0,      9,  1, 0, 1, 9, 32'h99,   0, 1));
    // Issue to rd9 on the edge rd9 commits: the set must win.
    vecs.push_back(mk(1, 9, 0, 0, 0,         0, 0, 0,      0,  1, 0, 0, 0, 0,        0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,         0, 0, 0,      9,  1, 1, 0, 0, 0,        0, 1));

    // Reset state.
    #2;
    chk("rst_async_we3", we3, 0);
    do_reset();
    chk("rst_we3", we3, 0);
    chk("rst_a3", a3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_q", q_count, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_ready", mem_ready, 1);

    // Table: drive at posedge+1, combinational checks at negedge,
    // registered checks at the following posedge+1.
    foreach (vecs[i]) begin
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
      rs1 = vecs[i].r1; rs2 = 0;
      @(negedge clock);
      chk($sformatf("v%0d_issue_ready", i), issue_ready, vecs[i].e_ir);
      chk($sformatf("v%0d_rs1_busy", i), rs1_busy, vecs[i].e_b1);
      chk($sformatf("v%0d_rs2_busy", i), rs2_busy, 0);
      @(posedge clock); #1;
      chk($sformatf("v%0d_we3", i), we3, vecs[i].e_we);
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_a3", i), a3, vecs[i].e_a3);
        chk($sformatf("v%0d_wd3", i), wd3, vecs[i].e_wd);
      end
      chk($sformatf("v%0d_q", i), q_count, vecs[i].e_q);
      chk($sformatf("v%0d_err", i), err, vecs[i].e_err);
    end
    idle(); rs1 = 0;

    // Queue fill with load backpressure, then in-order drain.
    do_reset();
    for (int r = 1; r <= 8; r++) issue_cycle(5'(r));
    begin
      int mi = 0;
      for (int c = 0; c < 8; c++) begin
        alu_valid = (c < 4);
        alu_rd    = (c < 4) ? 5'(c + 1) : 5'd0;
        alu_data  = 32'h100 + 32'(c + 1);
        mem_valid = (mi < 4);
        mem_rd    = 5'(5 + mi);
        mem_data  = 32'h200 + 32'(5 + mi);
        @(negedge clock);
        chk($sformatf("fill%0d_mem_ready", c), mem_ready, exp_mr[c]);
        if (mem_valid && exp_mr[c]) mi++;
        @(posedge clock); #1;
        chk($sformatf("fill%0d_we3", c), we3, 1);
        chk($sformatf("fill%0d_a3", c), a3, exp_a3[c]);
        chk($sformatf("fill%0d_wd3", c), wd3,
            (exp_a3[c] < 5) ? 32'h100 + 32'(exp_a3[c]) : 32'h200 + 32'(exp_a3[c]));
        chk($sformatf("fill%0d_q", c), q_count, exp_q[c]);
      end
      idle();
      @(posedge clock); #1;
      chk("fill_done_we3", we3, 0);
      chk("fill_err", err, 0);
    end

    // Asynchronous reset with entries queued and registers busy.
    do_reset();
    for (int r = 1; r <= 4; r++) issue_cycle(5'(r));
    alu_valid = 1; alu_rd = 1; alu_data = 32'hAA1;
    mem_valid = 1; mem_rd = 2; mem_data = 32'hBB2;
    @(posedge clock); #1;
    alu_rd = 3; alu_data = 32'hAA3;
    mem_rd = 4; mem_data = 32'hBB4;
    @(posedge clock); #1;
    idle();
    rs1 = 3; rs2 = 4;
    #1;
    chk("pre_rst_q", q_count, 2);
    chk("pre_rst_rs1_busy", rs1_busy, 1);
    chk("pre_rst_rs2_busy", rs2_busy, 1);
    #1 reset = 1;
    #1;
    chk("arst_we3", we3, 0);
    chk("arst_q", q_count, 0);
    chk("arst_rs1_busy", rs1_busy, 0);
    chk("arst_rs2_busy", rs2_busy, 0);
    @(negedge clock);
    reset = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      chk($sformatf("post_rst%0d_we3", c), we3, 0);
      chk($sformatf("post_rst%0d_q", c), q_count, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Owns the write side of the CPU register file. It drives the write-enable, write-address and write-data inputs of the 32x32 register file from two completion sources: a single-cycle ALU path and a variable-latency load path.
- Arbitrates between the two sources and buffers losers in a small queue.
- Keeps a per-register busy scoreboard so decode can stall on RAW and WAW hazards against pending writes.

Parameters:
- XLEN, 32, data width
- AW, 5, register address width (2^AW registers)
- QDEPTH, 4, writeback queue entries (power of two, >= 2)

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high
- issue_valid  in  1  decode issues an instruction with a destination register
- issue_rd  in  AW  destination of the issued instruction
- issue_ready  out  1  low when issue_rd is busy (WAW stall); combinational
- alu_valid  in  1  ALU result valid this cycle; no backpressure
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- mem_valid  in  1  load result valid
- mem_rd  in  AW  load destination
- mem_data  in  XLEN  load data
- mem_ready  out  1  queue can absorb two pushes; load unit holds mem_valid until ready
- rs1, rs2  in  AW  decode source operands
- rs1_busy, rs2_busy  out  1  busy[rsX] and rsX != 0; combinational
- we3  out  1  register file write enable, registered
- a3  out  AW  register file write address, registered
- wd3  out  XLEN  register file write data, registered
- q_count  out  log2(QDEPTH)+1  queue occupancy
- err  out  1  sticky protocol error

Behaviour:
- Reset values: we3=0, a3=0, wd3=0, err=0, q_count=0. All busy bits clear; queue empty. Reset mid-operation discards queued entries and pending busy bits.
- Destination x0:
  - Completions with rd=0 are dropped; they never queue and never assert we3.
  - An issue with rd=0 sets no busy bit, and issue_ready=1.
- Issue:
  - Accepted when issue_valid and issue_ready; sets busy[issue_rd] at the clock edge.
  - issue_ready = (issue_rd==0) or !busy[issue_rd].
- Accepted mem completion: mem_valid and mem_ready. mem_ready = q_count <= QDEPTH-2.
- Per-cycle write selection, priority order:
  - queue head
  - alu (if alu_valid and alu_rd != 0)
  - mem (if accepted and mem_rd != 0)
  - The winner loads we3/a3/wd3 at the edge. Any valid non-winner pushes to the queue, alu before mem if both push.
  - If there is no winner, we3=0 next cycle and a3/wd3 hold.
- Latency: a completion sampled at edge N with the queue empty gives we3=1 in cycle N+1; the register file commits at edge N+1.
- Queue entries drain one per cycle in FIFO order.
- Busy clear: busy[a3] clears at the edge where we3=1, which is the same edge the register file writes.
  - If an issue sets the same register on that edge, the set wins.
  - rsX_busy therefore deasserts the cycle after the commit edge, and a read in that cycle sees the new value.
- Queue: up to 2 pushes and 1 pop per cycle; q_count = pushes - pop accumulated. Because mem_ready is conservative, overflow cannot occur under legal use.
- err sets (sticky until reset) when either of these occurs:
  - an accepted completion targets a register whose busy bit is clear
  - an alu push would overflow the queue; the overflowing entry is dropped
- Same-register completions from alu and mem in one cycle are both written, alu first. Flag err only if busy was clear.

Decomposition:
- Package regfile_wb_pkg holds:
  - constants XLEN, AW, QDEPTH
  - typedef wb_entry_t {rd[AW-1:0], data[XLEN-1:0]}
  - localparam REG_ZERO = 0
- Sub-module wb_queue: 2-push/1-pop FIFO of wb_entry_t, with count output and async reset.
- The scoreboard, arbitration and output register live in the top level.

Test Plan:
- Reset, then issue rd=5 and alu_valid rd=5 data=0x1234 the next cycle. Expect rs1=5 busy=1 until the commit edge, we3=1 a3=5 wd3=0x1234 one cycle after alu_valid, then busy=0.
- alu rd=3 0xA and mem rd=4 0xB in the same cycle, both issued, queue empty. Expect we3 write of a3=3 then a3=4 on consecutive cycles, and q_count 1 then 0.
- Hold issued mem completions with alu traffic every cycle until q_count=3. Expect mem_ready=0 with no loss, and FIFO drain order preserved once alu stops.
- alu rd=0 data=0xFFFF_FFFF. Expect we3 stays 0, q_count=0, err=0. Issue rd=0 gives issue_ready=1.
- Issue rd=7 twice back-to-back. Expect issue_ready=0 on the second until rd=7 commits. An alu completion to unissued rd=9 gives err=1 while the write still occurs.
- Assert reset while q_count=2 and busy bits are set. Expect we3=0, q_count=0, all rsX_busy=0 immediately (asynchronous), and no queued entry written after release.
